// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and frame constants for the UART TX arbiter
package uart_pkg;

  typedef enum logic {
    S_ARB = 1'b0,
    S_OWN = 1'b1
  } eUartArbState;

  // start bit, 8 data bits, stop bit
  localparam int UART_FRAME_BAUDS = 10;

  function automatic int frame_ticks(input int ticks_per_baud);
    return UART_FRAME_BAUDS * ticks_per_baud;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - round-robin pick: first valid index at or after rr_ptr, wrapping
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             any_valid
);

  logic [N_REQ-1:0] rotated;
  int               offset;
  int               sum;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rotated = N_REQ'({valid, valid} >> rr_ptr);
    offset  = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = i;
      end
    end
    sum = int'(rr_ptr) + offset;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end
    win_idx   = IDX_W'(sum);
    any_valid = |valid;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter pacing strobes into a static-baud UART TX
// Optional stalled-owner lock revocation under UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TICKS_PER_BAUD = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               uart_stb,
  output logic [7:0]         uart_data,
  output logic [IDX_W-1:0]   grant_id,
  output logic               busy,
  output logic               timeout
);

  localparam int                FRAME      = frame_ticks(TICKS_PER_BAUD);
  localparam int                GW         = $clog2(FRAME + 1);
  localparam logic [GW-1:0]     GUARD_LOAD = GW'(FRAME);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_REQ - 1);

  eUartArbState     state;
  logic [IDX_W-1:0] rr_ptr;
  logic [GW-1:0]    guard;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_valid;
  logic             owner_last;
  logic [7:0]       owner_data;
  logic             slot_open;
  logic             hs;
  logic [IDX_W-1:0] next_ptr;

  uart_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .valid    (req_valid),
    .rr_ptr   (rr_ptr),
    .win_idx  (pick_idx),
    .any_valid(pick_any)
  );

  always_comb begin
    owner_valid = req_valid[grant_id];
    owner_last  = req_last[grant_id];
    owner_data  = req_data[{grant_id, 3'b000} +: 8];
    // guard models the transmitter's frame time, since it reports no busy
    slot_open   = (state == S_OWN) && (guard == '0) && !uart_stb;
    hs          = slot_open && owner_valid;
    next_ptr    = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
  end

  always_comb begin
    req_ready = '0;
    if (slot_open) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign busy = (state == S_OWN) || (guard != '0) || uart_stb;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int                 TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]    TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] idle_cnt;
  logic            owner_stalled;

  assign owner_stalled = (state == S_OWN) && (guard == '0) && !owner_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (!owner_stalled) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TO_LIMIT) begin
        idle_cnt <= '0;
        timeout  <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
`else
  logic owner_stalled;
  assign owner_stalled = 1'b0;
  // the lock is only ever released by req_last in this build
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ARB;
      rr_ptr    <= '0;
      grant_id  <= '0;
      guard     <= '0;
      uart_stb  <= 1'b0;
      uart_data <= '0;
    end else begin
      uart_stb <= hs;
      if (hs) begin
        uart_data <= owner_data;
      end

      if (hs) begin
        guard <= GUARD_LOAD;
      end else if (guard != '0) begin
        guard <= guard - 1'b1;
      end

      case (state)
        S_ARB: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            state    <= S_OWN;
          end
        end
        S_OWN: begin
          if (hs && owner_last) begin
            state  <= S_ARB;
            rr_ptr <= next_ptr;
          end else if (owner_stalled && (TIMEOUT_CYCLES > 0)) begin
`ifdef UART_ARB_TIMEOUT_EN
            if (idle_cnt == TO_LIMIT) begin
              state  <= S_ARB;
              rr_ptr <= next_ptr;
            end
`endif
          end
        end
        default: state <= S_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter (N_REQ=4, TICKS_PER_BAUD=2)
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        uart_stb;
  logic [7:0]  uart_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout;

  int vectors = 0;
  int miscompares = 0;
  int gap;
  int bad_ready;
  int bad_grant;
  int bad_timeout;

  uart_tx_arbiter #(
    .N_REQ         (4),
    .TICKS_PER_BAUD(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .uart_stb (uart_stb),
    .uart_data(uart_data),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    cyc(3);
    chk("rst_stb", uart_stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;

    // single-byte packet from req0
    cyc(1);
    chk("t1_arb_ready", req_ready, 4'b0000);
    req_valid = 4'b0001; req_data[7:0] = 8'hA5; req_last = 4'b0001;
    cyc(1);
    chk("t1_grant", grant_id, 0);
    chk("t1_ready", req_ready, 4'b0001);
    cyc(1);
    chk("t1_stb", uart_stb, 1);
    chk("t1_data", uart_data, 8'hA5);
    req_valid = 4'b0000;
    cyc(18);
    chk("t1_busy_inflight", busy, 1);
    cyc(2);
    chk("t1_busy_fall", busy, 0);
    chk("t1_stb_idle", uart_stb, 0);

    // 3-byte packet from req1 while req2 waits
    req_valid = 4'b0110; req_last = 4'b0100;
    req_data[15:8] = 8'h11; req_data[23:16] = 8'h77;
    cyc(1);
    chk("t2_grant1", grant_id, 1);
    chk("t2_hs1", req_ready, 4'b0010);
    cyc(1);
    chk("t2_data1", uart_data, 8'h11);
    req_data[15:8] = 8'h22;
    cyc(19);
    chk("t2_guard1", req_ready, 4'b0000);
    cyc(1);
    chk("t2_hs2", req_ready, 4'b0010);
    cyc(1);
    chk("t2_stb2", uart_stb, 1);
    chk("t2_data2", uart_data, 8'h22);
    req_data[15:8] = 8'h33; req_last = 4'b0110;
    cyc(19);
    chk("t2_guard2", req_ready, 4'b0000);
    cyc(1);
    chk("t2_hs3", req_ready, 4'b0010);
    cyc(1);
    chk("t2_data3", uart_data, 8'h33);
    req_valid = 4'b0100;
    cyc(1);
    chk("t2_grant2", grant_id, 2);
    chk("t2_grant2_guard", req_ready, 4'b0000);
    cyc(18);
    chk("t2_guard3", req_ready, 4'b0000);
    cyc(1);
    chk("t2_hs_req2", req_ready, 4'b0100);
    cyc(1);
    chk("t2_data_req2", uart_data, 8'h77);
    req_valid = 4'b0000;

    // reset in the middle of a frame
    cyc(4);
    chk("t4_busy_before", busy, 1);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("t4_stb", uart_stb, 0);
    chk("t4_busy", busy, 0);
    chk("t4_grant", grant_id, 0);
    chk("t4_ready", req_ready, 0);
    rst = 1'b0;
    req_valid = 4'b1000; req_data[31:24] = 8'h3C; req_last = 4'b1000;
    cyc(1);
    chk("t4_grant3", grant_id, 3);
    chk("t4_ready3", req_ready, 4'b1000);
    cyc(1);
    chk("t4_stb3", uart_stb, 1);
    chk("t4_data3", uart_data, 8'h3C);

    // all four requesters, single-byte packets
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'hB3B2B1B0;
    for (int k = 0; k < 5; k++) begin
      gap = 0;
      do begin
        cyc(1);
        gap++;
      end while (!uart_stb && gap < 40);
      chk($sformatf("t3_gap%0d", k), gap, 21);
      chk($sformatf("t3_grant%0d", k), grant_id, k % 4);
      chk($sformatf("t3_data%0d", k), uart_data, 8'hB0 + (k % 4));
    end

    // owner req3 stalls mid-packet while req0 waits
    req_valid = 4'b1000; req_last = 4'b0000; req_data[31:24] = 8'hC1;
    cyc(1);
    chk("t5_grant3", grant_id, 3);
    cyc(20);
    chk("t5_stb", uart_stb, 1);
    chk("t5_data", uart_data, 8'hC1);
    req_valid = 4'b0001; req_data[7:0] = 8'hD0; req_last = 4'b0001;
`ifdef UART_ARB_TIMEOUT_EN
    cyc(27);
    chk("t5_timeout_early", timeout, 0);
    cyc(1);
    chk("t5_timeout_pulse", timeout, 1);
    cyc(1);
    chk("t5_timeout_end", timeout, 0);
    chk("t5_regrant", grant_id, 0);
    chk("t5_ready0", req_ready, 4'b0001);
`else
    bad_ready = 0; bad_grant = 0; bad_timeout = 0;
    for (int c = 0; c < 200; c++) begin
      cyc(1);
      if (req_ready[0]) bad_ready++;
      if (grant_id != 2'd3) bad_grant++;
      if (timeout) bad_timeout++;
    end
    chk("t6_req0_ready_cycles", bad_ready, 0);
    chk("t6_grant_lost_cycles", bad_grant, 0);
    chk("t6_timeout_cycles", bad_timeout, 0);
    chk("t6_busy_locked", busy, 1);
`endif
    req_valid = '0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
